// File: rtl/misr_pkg.sv
// Shared types and defaults for the response MISR capture stage.
// Also provides a reference single-step MISR update.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_PAT_W  = 7;
  localparam int DEF_RESP_W = 1;
  localparam int DEF_SIG_W  = 16;

  localparam logic [DEF_SIG_W-1:0] DEF_POLY = 16'h1021;
  localparam logic [DEF_SIG_W-1:0] DEF_SEED = 16'hFFFF;

  function automatic logic [DEF_SIG_W-1:0] misr_step(
    input logic [DEF_SIG_W-1:0] sig,
    input logic [DEF_SIG_W-1:0] data,
    input logic [DEF_SIG_W-1:0] poly
  );
    logic [DEF_SIG_W-1:0] fb;
    fb = sig[DEF_SIG_W-1] ? poly : '0;
    return {sig[DEF_SIG_W-2:0], 1'b0} ^ fb ^ data;
  endfunction

endpackage

// File: rtl/response_misr_capture_if.sv
// Pattern/response stream into the capture stage.
// Valid/ready handshake; one pair per accepted cycle.
interface response_misr_capture_if
  import misr_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int RESP_W = DEF_RESP_W
);

  logic              pat_valid;
  logic [PAT_W-1:0]  pat;
  logic [RESP_W-1:0] resp;
  logic              pat_ready;

  modport master (
    output pat_valid,
    output pat,
    output resp,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat,
    input  resp,
    output pat_ready
  );

endinterface

// File: rtl/misr_reg.sv
// Multiple-input signature register with seed load.
// Reusable wherever a compact running signature is needed.
module misr_reg #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] fb;

  // Next signature: seed on load, shift/feedback/xor on enable
  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[SIG_W-1] ? POLY : '0;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb ^ data;
    end
  end

  // Signature register, seeded on reset
  always_ff @(posedge clk) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/response_misr_capture.sv
// Compacts an exhaustive pattern/response sweep into a MISR
// signature, counts ones, records the first one, checks order.
module response_misr_capture
  import misr_pkg::*;
#(
  parameter int               PAT_W  = DEF_PAT_W,
  parameter int               RESP_W = DEF_RESP_W,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
  input  logic                   CK,
  input  logic                   reset,
  input  logic                   start,
  response_misr_capture_if.slave bus,
  output logic                   busy,
  output logic                   done,
  output logic [SIG_W-1:0]       signature,
  output logic [PAT_W:0]         ones_count,
  output logic [PAT_W-1:0]       first_one_pat,
  output logic                   first_one_valid,
  output logic                   seq_error
);

  localparam int              DW   = PAT_W + RESP_W;
  localparam logic [PAT_W-1:0] LAST = '1;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PAT_W:0]   ones_q, ones_d;
  logic [PAT_W-1:0] first_q, first_d;
  logic             fv_q, fv_d;
  logic             seq_q, seq_d;
  logic [PAT_W-1:0] exp_q, exp_d;
  logic             load;
  logic             accept;
  logic [SIG_W-1:0] data_w;

  assign accept = busy_q & bus.pat_valid;

  // Pattern in the upper bits, response in the LSBs
  always_comb begin
    data_w         = '0;
    data_w[DW-1:0] = {bus.pat, bus.resp};
  end

  // Next-state for FSM, counters and capture flags
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    first_d = first_q;
    fv_d    = fv_q;
    seq_d   = seq_q;
    exp_d   = exp_q;
    load    = 1'b0;
    if (start && state_q != RUN) begin
      state_d = RUN;
      ones_d  = '0;
      first_d = '0;
      fv_d    = 1'b0;
      seq_d   = 1'b0;
      exp_d   = '0;
      load    = 1'b1;
    end else if (accept) begin
      if (|bus.resp) begin
        ones_d = ones_q + (PAT_W+1)'(1);
        if (!fv_q) begin
          first_d = bus.pat;
          fv_d    = 1'b1;
        end
      end
      if (bus.pat != exp_q) seq_d = 1'b1;
      exp_d = exp_q + PAT_W'(1);
      if (exp_q == LAST) state_d = DONE;
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset wins over everything
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      first_q <= '0;
      fv_q    <= 1'b0;
      seq_q   <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      first_q <= first_d;
      fv_q    <= fv_d;
      seq_q   <= seq_d;
      exp_q   <= exp_d;
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (CK),
    .rst  (reset),
    .load (load),
    .en   (accept),
    .data (data_w),
    .sig  (signature)
  );

  assign bus.pat_ready   = busy_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign ones_count      = ones_q;
  assign first_one_pat   = first_q;
  assign first_one_valid = fv_q;
  assign seq_error       = seq_q;

endmodule

// File: tb/tb_response_misr_capture.sv
// Bench for response_misr_capture: randomized stimulus against
// a sweep-level reference model.
module tb_response_misr_capture;

  logic        CK = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  ones_count;
  logic [6:0]  first_one_pat;
  logic        first_one_valid;
  logic        seq_error;

  int nv = 0;
  int ne = 0;

  int m_st, m_sig, m_ones, m_first, m_fv, m_seq, m_cnt;
  int clean_sig;

  response_misr_capture_if #(.PAT_W(7), .RESP_W(1)) bus ();

  response_misr_capture dut (
    .CK              (CK),
    .reset           (reset),
    .start           (start),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .signature       (signature),
    .ones_count      (ones_count),
    .first_one_pat   (first_one_pat),
    .first_one_valid (first_one_valid),
    .seq_error       (seq_error)
  );

  always #5 CK = ~CK;

  function automatic int sstep(int s, int d);
    int fb;
    fb = (s / 32768) % 2;
    s  = (s * 2) % 65536;
    if (fb == 1) s = s ^ 'h1021;
    return s ^ d;
  endfunction

  function automatic int sweep_sig(int hot);
    int s;
    s = 'hFFFF;
    for (int p = 0; p < 128; p++)
      s = sstep(s, p * 2 + ((p == hot) ? 1 : 0));
    return s;
  endfunction

  task automatic cyc(bit st, bit v, int p, bit r, bit rs);
    start         = st;
    bus.pat_valid = v;
    bus.pat       = p[6:0];
    bus.resp      = r;
    reset         = rs;
    @(posedge CK);
    #1;
    if (rs) begin
      m_st = 0; m_sig = 'hFFFF; m_ones = 0; m_first = 0;
      m_fv = 0; m_seq = 0; m_cnt = 0;
    end else if (st && m_st != 1) begin
      m_st = 1; m_sig = 'hFFFF; m_ones = 0; m_first = 0;
      m_fv = 0; m_seq = 0; m_cnt = 0;
    end else if (m_st == 1 && v) begin
      m_sig = sstep(m_sig, p * 2 + r);
      if (r) begin
        m_ones++;
        if (m_fv == 0) begin m_first = p; m_fv = 1; end
      end
      if (p != m_cnt) m_seq = 1;
      m_cnt++;
      if (m_cnt == 128) m_st = 2;
    end
  endtask

  task automatic test_reset;
    cyc(0, 1, 3, 1, 1);
    cyc(1, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++)
      cyc(0, 1'($urandom % 2), int'($urandom % 128), 1'($urandom % 2), 0);
    nv++; if (bus.pat_ready !== 1'b0) begin ne++;
      $display("FAIL rst_ready got %0b exp 0", bus.pat_ready); end
    nv++; if (busy !== 1'b0) begin ne++;
      $display("FAIL rst_busy got %0b exp 0", busy); end
    nv++; if (done !== 1'b0) begin ne++;
      $display("FAIL rst_done got %0b exp 0", done); end
    nv++; if (signature !== 16'hFFFF) begin ne++;
      $display("FAIL rst_sig got %0h exp ffff", signature); end
    nv++; if (ones_count !== 8'd0 || first_one_pat !== 7'd0 ||
              first_one_valid !== 1'b0 || seq_error !== 1'b0) begin ne++;
      $display("FAIL rst_counts got %0d/%0d/%0b/%0b exp 0/0/0/0",
               ones_count, first_one_pat, first_one_valid, seq_error); end
  endtask

  task automatic test_two_accepts;
    cyc(1, 1, 0, 1, 0);
    nv++; if (busy !== 1'b1 || signature !== 16'hFFFF) begin ne++;
      $display("FAIL start_cycle got busy %0b sig %0h exp 1 ffff",
               busy, signature); end
    cyc(0, 1, 0, 1, 0);
    nv++; if (signature !== 16'hEFDE) begin ne++;
      $display("FAIL sig_first got %0h exp efde", signature); end
    cyc(0, 1, 1, 0, 0);
    nv++; if (signature !== 16'hCF9F) begin ne++;
      $display("FAIL sig_second got %0h exp cf9f", signature); end
    nv++; if (ones_count !== 8'd1 || first_one_pat !== 7'd0 ||
              first_one_valid !== 1'b1) begin ne++;
      $display("FAIL two_first got %0d/%0d/%0b exp 1/0/1",
               ones_count, first_one_pat, first_one_valid); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_full_sweep;
    clean_sig = sweep_sig(-1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) begin
      cyc(0, 1, i, 0, 0);
      if (i == 126) begin
        nv++; if (done !== 1'b0 || bus.pat_ready !== 1'b1) begin ne++;
          $display("FAIL early_done got %0b/%0b exp 0/1",
                   done, bus.pat_ready); end
      end
    end
    nv++; if (done !== 1'b1 || bus.pat_ready !== 1'b0 || busy !== 1'b0) begin
      ne++; $display("FAIL sweep_done got %0b/%0b/%0b exp 1/0/0",
                     done, bus.pat_ready, busy); end
    nv++; if (seq_error !== 1'b0 || ones_count !== 8'd0 ||
              first_one_valid !== 1'b0) begin ne++;
      $display("FAIL sweep_flags got %0b/%0d/%0b exp 0/0/0",
               seq_error, ones_count, first_one_valid); end
    nv++; if (signature !== clean_sig[15:0]) begin ne++;
      $display("FAIL sweep_sig got %0h exp %0h", signature, clean_sig); end
  endtask

  task automatic test_gapped;
    int acc = 0;
    int guard = 0;
    bit tog = 0;
    int gs;
    gs = sweep_sig(85);
    cyc(1, 0, 0, 0, 0);
    while (acc < 128 && guard < 400) begin
      if (tog) begin
        cyc(0, 1, acc, acc == 85, 0);
        acc++;
      end else begin
        cyc(0, 0, int'($urandom % 128), 1'($urandom % 2), 0);
      end
      tog = ~tog;
      guard++;
    end
    nv++; if (acc != 128 || done !== 1'b1) begin ne++;
      $display("FAIL gap_done got %0b after %0d exp 1 after 128", done, acc); end
    nv++; if (ones_count !== 8'd1 || first_one_pat !== 7'd85 ||
              first_one_valid !== 1'b1) begin ne++;
      $display("FAIL gap_first got %0d/%0d/%0b exp 1/85/1",
               ones_count, first_one_pat, first_one_valid); end
    nv++; if (signature !== gs[15:0]) begin ne++;
      $display("FAIL gap_sig got %0h exp %0h", signature, gs); end
  endtask

  task automatic test_seq_error;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) begin
      cyc(0, 1, (i == 4) ? 5 : i, 0, 0);
      if (i == 3) begin
        nv++; if (seq_error !== 1'b0) begin ne++;
          $display("FAIL seq_pre got %0b exp 0", seq_error); end
      end
      if (i == 4) begin
        nv++; if (seq_error !== 1'b1) begin ne++;
          $display("FAIL seq_set got %0b exp 1", seq_error); end
      end
    end
    nv++; if (seq_error !== 1'b1 || done !== 1'b1) begin ne++;
      $display("FAIL seq_hold got %0b/%0b exp 1/1", seq_error, done); end
    nv++; if (signature !== m_sig[15:0]) begin ne++;
      $display("FAIL seq_sig got %0h exp %0h", signature, m_sig); end
    cyc(1, 0, 0, 0, 0);
    nv++; if (seq_error !== 1'b0 || busy !== 1'b1) begin ne++;
      $display("FAIL seq_clear got %0b/%0b exp 0/1", seq_error, busy); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 1, i, (i % 3) == 0, 0);
    cyc(1, 1, 50, 1, 1);
    nv++; if (busy !== 1'b0 || bus.pat_ready !== 1'b0 || done !== 1'b0) begin
      ne++; $display("FAIL mid_state got %0b/%0b/%0b exp 0/0/0",
                     busy, bus.pat_ready, done); end
    nv++; if (signature !== 16'hFFFF || ones_count !== 8'd0 ||
              first_one_valid !== 1'b0 || seq_error !== 1'b0) begin ne++;
      $display("FAIL mid_vals got %0h/%0d/%0b/%0b exp ffff/0/0/0",
               signature, ones_count, first_one_valid, seq_error); end
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) cyc(0, 1, i, 0, 0);
    nv++; if (done !== 1'b1 || signature !== clean_sig[15:0]) begin ne++;
      $display("FAIL mid_resweep got %0b/%0h exp 1/%0h",
               done, signature, clean_sig); end
  endtask

  task automatic test_random;
    int guard = 0;
    int p;
    int held;
    cyc(1, 0, 0, 0, 0);
    while (m_st != 2 && guard < 1000) begin
      p = (($urandom % 16) == 0) ? int'($urandom % 128) : (m_cnt % 128);
      cyc(1'(($urandom % 20) == 0), 1'($urandom % 2), p,
          1'(($urandom % 4) == 0), 0);
      nv++; if (signature !== m_sig[15:0] || ones_count !== m_ones[7:0] ||
                busy !== (m_st == 1)) begin ne++;
        $display("FAIL rnd_step got %0h/%0d/%0b exp %0h/%0d/%0b",
                 signature, ones_count, busy, m_sig, m_ones, m_st == 1); end
      guard++;
    end
    nv++; if (m_st != 2 || done !== 1'b1) begin ne++;
      $display("FAIL rnd_done got %0b exp 1", done); end
    nv++; if (first_one_pat !== m_first[6:0] || first_one_valid !== m_fv[0] ||
              seq_error !== m_seq[0]) begin ne++;
      $display("FAIL rnd_flags got %0d/%0b/%0b exp %0d/%0b/%0b",
               first_one_pat, first_one_valid, seq_error,
               m_first, m_fv, m_seq); end
    held = m_sig;
    for (int i = 0; i < 5; i++) cyc(0, 1, i, 1, 0);
    nv++; if (signature !== held[15:0] || done !== 1'b1 ||
              ones_count !== m_ones[7:0]) begin ne++;
      $display("FAIL done_hold got %0h/%0b exp %0h/1",
               signature, done, held); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.pat_valid = 1'b0;
    bus.pat = '0;
    bus.resp = '0;
    test_reset();
    test_two_accepts();
    test_full_sweep();
    test_gapped();
    test_seq_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end

endmodule
